// File: rtl/id_ex_stage_reg_pkg.sv
// Shared pipeline definitions: ALU op classes and the control bundle carried
// by the ID/EX, EX/MEM and MEM/WB registers.
package id_ex_stage_reg_pkg;

    localparam logic [1:0] ALU_OP_ADD    = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
    localparam logic [1:0] ALU_OP_RTYPE  = 2'b10;
    localparam logic [1:0] ALU_OP_ITYPE  = 2'b11;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(8'h00);

    // An invalid slot must never carry live control.
    function automatic ctrl_t ctrl_gate(input ctrl_t c, input logic vld);
        return vld ? c : CTRL_BUBBLE;
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_if.sv
// ID-side inputs and EX-side outputs of the ID/EX pipeline register.
interface id_ex_stage_reg_if #(parameter int XLEN = 32);

    logic            id_valid;
    logic [XLEN-1:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd;
    logic [2:0]      id_funct3;
    logic            id_funct7_b5;
    logic            id_reg_write, id_mem_read, id_mem_write;
    logic            id_mem_to_reg, id_alu_src, id_branch;
    logic [1:0]      id_alu_op;
    logic            flush, hold;

    logic            id_ex_valid;
    logic [XLEN-1:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]      id_ex_reg_rs1, id_ex_reg_rs2, id_ex_reg_rd;
    logic [2:0]      id_ex_funct3;
    logic            id_ex_funct7_b5;
    logic            id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
    logic            id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch;
    logic [1:0]      id_ex_alu_op;
    logic            load_use_stall;

    modport master (
        output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7_b5,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_branch, id_alu_op, flush, hold,
        input  id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_reg_rs1, id_ex_reg_rs2, id_ex_reg_rd, id_ex_funct3,
               id_ex_funct7_b5, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
               id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch, id_ex_alu_op,
               load_use_stall
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
               id_rs1, id_rs2, id_rd, id_funct3, id_funct7_b5,
               id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg,
               id_alu_src, id_branch, id_alu_op, flush, hold,
        output id_ex_valid, id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
               id_ex_reg_rs1, id_ex_reg_rs2, id_ex_reg_rd, id_ex_funct3,
               id_ex_funct7_b5, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
               id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch, id_ex_alu_op,
               load_use_stall
    );

endinterface

// File: rtl/id_ex_stage_reg_load_use_detector.sv
// Load-use hazard detector: a load in EX whose rd feeds the instruction in ID.
module load_use_detector (
    input  logic       ex_valid,
    input  logic       ex_mem_read,
    input  logic [4:0] ex_rd,
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       flush,
    output logic       stall
);

    logic rd_match;

    assign rd_match = (ex_rd == id_rs1) || (ex_rd == id_rs2);

    // A flushed ID instruction is being killed, so it cannot be stalled.
    assign stall = ex_valid && ex_mem_read && (ex_rd != 5'd0) && id_valid
                   && rd_match && !flush;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and hold.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int XLEN = 32
) (
    input logic             clk,
    input logic             reset,
    id_ex_stage_reg_if.slave bus
);

    ctrl_t           ctrl_p0, ctrl_p1;
    logic            vld_p1;
    logic [XLEN-1:0] pc_p1, rs1_data_p1, rs2_data_p1, imm_p1;
    logic [4:0]      rs1_p1, rs2_p1, rd_p1;
    logic [2:0]      funct3_p1;
    logic            funct7_b5_p1;
    logic            load_use_stall;

    assign ctrl_p0 = '{reg_write:  bus.id_reg_write,
                       mem_read:   bus.id_mem_read,
                       mem_write:  bus.id_mem_write,
                       mem_to_reg: bus.id_mem_to_reg,
                       alu_src:    bus.id_alu_src,
                       branch:     bus.id_branch,
                       alu_op:     bus.id_alu_op};

    load_use_detector u_load_use_detector (
        .ex_valid    (vld_p1),
        .ex_mem_read (ctrl_p1.mem_read),
        .ex_rd       (rd_p1),
        .id_valid    (bus.id_valid),
        .id_rs1      (bus.id_rs1),
        .id_rs2      (bus.id_rs2),
        .flush       (bus.flush),
        .stall       (load_use_stall)
    );

    // ---- ID -> EX boundary ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1       <= 1'b0;
            ctrl_p1      <= CTRL_BUBBLE;
            pc_p1        <= '0;
            rs1_data_p1  <= '0;
            rs2_data_p1  <= '0;
            imm_p1       <= '0;
            rs1_p1       <= 5'd0;
            rs2_p1       <= 5'd0;
            rd_p1        <= 5'd0;
            funct3_p1    <= 3'd0;
            funct7_b5_p1 <= 1'b0;
        end else if (bus.flush || (!bus.hold && load_use_stall)) begin
            // Bubble: only control and register indices need to be clean.
            vld_p1  <= 1'b0;
            ctrl_p1 <= CTRL_BUBBLE;
            rs1_p1  <= 5'd0;
            rs2_p1  <= 5'd0;
            rd_p1   <= 5'd0;
        end else if (!bus.hold) begin
            vld_p1       <= bus.id_valid;
            ctrl_p1      <= ctrl_gate(ctrl_p0, bus.id_valid);
            rs1_p1       <= bus.id_valid ? bus.id_rs1 : 5'd0;
            rs2_p1       <= bus.id_valid ? bus.id_rs2 : 5'd0;
            rd_p1        <= bus.id_valid ? bus.id_rd  : 5'd0;
            pc_p1        <= bus.id_pc;
            rs1_data_p1  <= bus.id_rs1_data;
            rs2_data_p1  <= bus.id_rs2_data;
            imm_p1       <= bus.id_imm;
            funct3_p1    <= bus.id_funct3;
            funct7_b5_p1 <= bus.id_funct7_b5;
        end
    end

    assign bus.id_ex_valid      = vld_p1;
    assign bus.id_ex_pc         = pc_p1;
    assign bus.id_ex_rs1_data   = rs1_data_p1;
    assign bus.id_ex_rs2_data   = rs2_data_p1;
    assign bus.id_ex_imm        = imm_p1;
    assign bus.id_ex_reg_rs1    = rs1_p1;
    assign bus.id_ex_reg_rs2    = rs2_p1;
    assign bus.id_ex_reg_rd     = rd_p1;
    assign bus.id_ex_funct3     = funct3_p1;
    assign bus.id_ex_funct7_b5  = funct7_b5_p1;
    assign bus.id_ex_reg_write  = ctrl_p1.reg_write;
    assign bus.id_ex_mem_read   = ctrl_p1.mem_read;
    assign bus.id_ex_mem_write  = ctrl_p1.mem_write;
    assign bus.id_ex_mem_to_reg = ctrl_p1.mem_to_reg;
    assign bus.id_ex_alu_src    = ctrl_p1.alu_src;
    assign bus.id_ex_branch     = ctrl_p1.branch;
    assign bus.id_ex_alu_op     = ctrl_p1.alu_op;
    assign bus.load_use_stall   = load_use_stall;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for the ID/EX pipeline register.
module tb_id_ex_stage_reg;
    import id_ex_stage_reg_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    id_ex_stage_reg_if #(.XLEN(32)) bus ();

    id_ex_stage_reg #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ld = 1 drives a load (lw), otherwise an R-type ALU instruction.
    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] imm, input logic ld);
        bus.id_valid     = v;
        bus.id_pc        = pc;
        bus.id_rs1_data  = pc ^ 32'hA5A5_0000;
        bus.id_rs2_data  = pc ^ 32'h5A5A_0000;
        bus.id_imm       = imm;
        bus.id_rs1       = rs1;
        bus.id_rs2       = rs2;
        bus.id_rd        = rd;
        bus.id_funct3    = ld ? 3'b010 : 3'b000;
        bus.id_funct7_b5 = 1'b0;
        bus.id_reg_write = 1'b1;
        bus.id_mem_read  = ld;
        bus.id_mem_write = 1'b0;
        bus.id_mem_to_reg = ld;
        bus.id_alu_src   = ld;
        bus.id_branch    = 1'b0;
        bus.id_alu_op    = ld ? ALU_OP_ADD : ALU_OP_RTYPE;
        #1;
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.hold  = 1'b0;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_valid", {31'd0, bus.id_ex_valid}, 32'd0);
        chk("rst_reg_write", {31'd0, bus.id_ex_reg_write}, 32'd0);
        chk("rst_pc", bus.id_ex_pc, 32'd0);
        chk("rst_stall", {31'd0, bus.load_use_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Normal flow: four ALU instructions back to back
        for (int k = 1; k <= 4; k++) begin
            set_id(1'b1, 32'h40 + 4 * k, 5'(k + 8), 5'(k + 16), 5'(k), 32'(k), 1'b0);
            chk("flow_stall", {31'd0, bus.load_use_stall}, 32'd0);
            tick();
            chk("flow_rd", {27'd0, bus.id_ex_reg_rd}, 32'(k));
            chk("flow_pc", bus.id_ex_pc, 32'h40 + 4 * k);
            chk("flow_valid", {31'd0, bus.id_ex_valid}, 32'd1);
        end
        chk("flow_alu_op", {30'd0, bus.id_ex_alu_op}, 32'd2);

        // Load-use: lw x5 then add x6,x5,x1
        set_id(1'b1, 32'h80, 5'd2, 5'd0, 5'd5, 32'h4, 1'b1);
        tick();
        chk("lw_mem_read", {31'd0, bus.id_ex_mem_read}, 32'd1);
        set_id(1'b1, 32'h84, 5'd5, 5'd1, 5'd6, 32'h0, 1'b0);
        chk("lu_stall", {31'd0, bus.load_use_stall}, 32'd1);
        tick();
        chk("lu_bub_valid", {31'd0, bus.id_ex_valid}, 32'd0);
        chk("lu_bub_reg_write", {31'd0, bus.id_ex_reg_write}, 32'd0);
        chk("lu_bub_rd", {27'd0, bus.id_ex_reg_rd}, 32'd0);
        chk("lu_bub_alu_op", {30'd0, bus.id_ex_alu_op}, 32'd0);
        chk("lu_stall_one_cycle", {31'd0, bus.load_use_stall}, 32'd0);
        tick();
        chk("lu_cap_valid", {31'd0, bus.id_ex_valid}, 32'd1);
        chk("lu_cap_rs1", {27'd0, bus.id_ex_reg_rs1}, 32'd5);
        chk("lu_cap_rd", {27'd0, bus.id_ex_reg_rd}, 32'd6);

        // lw x0 never stalls
        set_id(1'b1, 32'h90, 5'd2, 5'd0, 5'd0, 32'h0, 1'b1);
        tick();
        set_id(1'b1, 32'h94, 5'd0, 5'd0, 5'd7, 32'h0, 1'b0);
        chk("x0_no_stall", {31'd0, bus.load_use_stall}, 32'd0);
        tick();
        chk("x0_cap_rd", {27'd0, bus.id_ex_reg_rd}, 32'd7);

        // lw x5 with unrelated sources
        set_id(1'b1, 32'hA0, 5'd2, 5'd0, 5'd5, 32'h0, 1'b1);
        tick();
        set_id(1'b1, 32'hA4, 5'd6, 5'd7, 5'd8, 32'h0, 1'b0);
        chk("nodep_no_stall", {31'd0, bus.load_use_stall}, 32'd0);
        tick();
        chk("nodep_rd", {27'd0, bus.id_ex_reg_rd}, 32'd8);
        chk("nodep_rs2", {27'd0, bus.id_ex_reg_rs2}, 32'd7);

        // rs1 = rs2 = load rd: single-cycle stall
        set_id(1'b1, 32'hB0, 5'd2, 5'd0, 5'd5, 32'h0, 1'b1);
        tick();
        set_id(1'b1, 32'hB4, 5'd5, 5'd5, 5'd9, 32'h0, 1'b0);
        chk("dual_stall", {31'd0, bus.load_use_stall}, 32'd1);
        tick();
        chk("dual_bub_valid", {31'd0, bus.id_ex_valid}, 32'd0);
        chk("dual_stall_clear", {31'd0, bus.load_use_stall}, 32'd0);
        tick();
        chk("dual_cap_rd", {27'd0, bus.id_ex_reg_rd}, 32'd9);

        // Flush beats load-use
        set_id(1'b1, 32'hC0, 5'd2, 5'd0, 5'd5, 32'h0, 1'b1);
        tick();
        set_id(1'b1, 32'hC4, 5'd5, 5'd3, 5'd10, 32'h0, 1'b0);
        bus.flush = 1'b1;
        #1;
        chk("flush_stall", {31'd0, bus.load_use_stall}, 32'd0);
        tick();
        bus.flush = 1'b0;
        chk("flush_rd", {27'd0, bus.id_ex_reg_rd}, 32'd0);
        chk("flush_valid", {31'd0, bus.id_ex_valid}, 32'd0);
        chk("flush_mem_read", {31'd0, bus.id_ex_mem_read}, 32'd0);
        tick();
        chk("post_flush_rd", {27'd0, bus.id_ex_reg_rd}, 32'd10);

        // Hold for three cycles with changing inputs
        set_id(1'b1, 32'hD0, 5'd1, 5'd2, 5'd11, 32'h10, 1'b0);
        tick();
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 32'hD4 + 4 * i, 5'd3, 5'd4, 5'(12 + i), 32'h20 + i, 1'b0);
            tick();
            chk("hold_imm", bus.id_ex_imm, 32'h10);
            chk("hold_rd", {27'd0, bus.id_ex_reg_rd}, 32'd11);
        end
        set_id(1'b1, 32'hE0, 5'd3, 5'd4, 5'd20, 32'h99, 1'b0);
        bus.hold = 1'b0;
        tick();
        chk("release_imm", bus.id_ex_imm, 32'h99);
        chk("release_rd", {27'd0, bus.id_ex_reg_rd}, 32'd20);

        // Hold and flush together: flush wins
        bus.hold = 1'b1;
        bus.flush = 1'b1;
        tick();
        chk("holdflush_valid", {31'd0, bus.id_ex_valid}, 32'd0);
        bus.hold = 1'b0;
        bus.flush = 1'b0;

        // Stall visible while held, bubble only after release
        set_id(1'b1, 32'hF0, 5'd2, 5'd0, 5'd5, 32'h0, 1'b1);
        tick();
        bus.hold = 1'b1;
        set_id(1'b1, 32'hF4, 5'd5, 5'd0, 5'd13, 32'h0, 1'b0);
        chk("hold_stall", {31'd0, bus.load_use_stall}, 32'd1);
        tick();
        chk("hold_keep_load", {31'd0, bus.id_ex_mem_read}, 32'd1);
        chk("hold_stall_still", {31'd0, bus.load_use_stall}, 32'd1);
        bus.hold = 1'b0;
        tick();
        chk("hold_release_bub", {31'd0, bus.id_ex_valid}, 32'd0);
        tick();
        chk("hold_release_cap", {27'd0, bus.id_ex_reg_rd}, 32'd13);

        // Invalid input loads clean control
        set_id(1'b0, 32'h110, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1);
        tick();
        chk("inv_valid", {31'd0, bus.id_ex_valid}, 32'd0);
        chk("inv_reg_write", {31'd0, bus.id_ex_reg_write}, 32'd0);
        chk("inv_mem_read", {31'd0, bus.id_ex_mem_read}, 32'd0);
        chk("inv_rd", {27'd0, bus.id_ex_reg_rd}, 32'd0);

        // Asynchronous reset during a pending stall
        set_id(1'b1, 32'h100, 5'd2, 5'd0, 5'd5, 32'h0, 1'b1);
        tick();
        chk("pre_rst_pc", bus.id_ex_pc, 32'h100);
        chk("pre_rst_reg_write", {31'd0, bus.id_ex_reg_write}, 32'd1);
        set_id(1'b1, 32'h104, 5'd5, 5'd0, 5'd6, 32'h0, 1'b0);
        chk("pre_rst_stall", {31'd0, bus.load_use_stall}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pc", bus.id_ex_pc, 32'd0);
        chk("mid_rst_reg_write", {31'd0, bus.id_ex_reg_write}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.id_ex_valid}, 32'd0);
        chk("mid_rst_rd", {27'd0, bus.id_ex_reg_rd}, 32'd0);
        chk("mid_rst_stall", {31'd0, bus.load_use_stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("post_rst_cap_pc", bus.id_ex_pc, 32'h104);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_stage_reg.md
# id_ex_stage_reg

- Pipeline register between the ID and EX stages of the 5-stage RV32I core.
- Captures decoded operands, register indices and control fields each cycle and presents them to EX, including the `id_ex_reg_rs1`/`id_ex_reg_rs2` indices used by the forwarding unit.
- Contains the load-use hazard detector: it raises a stall for IF/ID and the PC, and injects a bubble into EX.
- Also handles branch flush and external hold requests.

## Interface
Parameters:
- XLEN, 32, datapath width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decoded values
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- id_funct3  in  3; id_funct7_b5  in  1  ALU qualifiers
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_branch  in  1 each  control
- id_alu_op  in  2  ALU op class
- flush  in  1  branch taken in EX; kill the younger instruction
- hold  in  1  downstream stall (e.g. memory busy); freeze the register
- id_ex_valid  out  1  EX slot holds a real instruction
- id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm  out  XLEN each
- id_ex_reg_rs1, id_ex_reg_rs2, id_ex_reg_rd  out  5 each
- id_ex_funct3  out  3; id_ex_funct7_b5  out  1
- id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src, id_ex_branch  out  1 each
- id_ex_alu_op  out  2
- load_use_stall  out  1  freeze PC and IF/ID this cycle

## Operation
**Hazard detection (combinational, from registered state):**
- load_use_stall = id_ex_valid & id_ex_mem_read & (id_ex_reg_rd != 0) & id_valid & (id_ex_reg_rd == id_rs1 | id_ex_reg_rd == id_rs2).
- It is forced to 0 when flush = 1, because the ID instruction is being killed.

**Per-edge update, highest priority first:**
1. flush: load a bubble.
2. hold: keep every field unchanged. load_use_stall is still output, computed from the held contents.
3. load_use_stall: load a bubble. EX receives a NOP, and ID re-presents the same instruction next cycle.
4. Otherwise: load all id_* inputs; id_ex_valid <= id_valid.

**Bubble:**
- id_ex_valid, all control bits, id_ex_alu_op, id_ex_reg_rd, id_ex_reg_rs1 and id_ex_reg_rs2 go to 0.
- Datapath fields (pc, data, imm, funct) may keep their old values; only control must be clean.
- A bubble never writes a register or memory, and never matches in forwarding because rd = 0.

**Invalid input:** when id_valid = 0 in the normal case, control outputs load as 0 (same as a bubble).

## Timing
- Latency is 1 cycle from ID inputs to id_ex_* outputs.
- load_use_stall is combinational within the cycle. It asserts for exactly one cycle per load-use pair; the next cycle the load has moved to MEM.
- Reset (asynchronous, takes effect immediately, including mid-stall): every output goes to 0, including id_ex_valid and load_use_stall.
- First capture happens on the first rising edge after reset deasserts.
- flush and load-use in the same cycle: flush wins and load_use_stall is 0.
- hold and flush in the same cycle: flush wins.
- A load followed by an instruction with rs1 = rs2 = load rd: still a single-cycle stall.
- A load with rd = x0 never stalls.

## Structure
- The shared pipeline package holds:
  - ALU_OP_* localparams (2-bit);
  - the control-bundle field list, reused by the EX/MEM and MEM/WB registers;
  - the zero/bubble control constant.
- A sub-module `load_use_detector` (purely combinational) keeps the hazard equation testable on its own; the register process lives in this block.

## Test plan
- **Reset mid-operation:** assert reset while id_ex_reg_write = 1 and id_ex_pc = 0x100 -> all outputs 0 immediately, before any clock edge.
- **Load-use stall:** lw x5 in EX, ID has add x6,x5,x1 -> load_use_stall = 1 for one cycle; next edge id_ex_valid = 0 and id_ex_reg_write = 0; following edge the add is captured with id_ex_reg_rs1 = 5.
- **No false stall:** lw x0 in EX with ID rs1 = 0 -> no stall. lw x5 with ID rs1 = 6, rs2 = 7 -> no stall, normal capture.
- **Flush priority:** flush = 1 together with a load-use condition -> load_use_stall = 0; next edge bubble with id_ex_reg_rd = 0.
- **Hold:** hold = 1 for 3 cycles with changing id_* inputs -> outputs unchanged (e.g. id_ex_imm stays 0x00000010). On release, the current inputs are captured.
- **Normal flow:** 4 back-to-back ALU instructions with rd = 1,2,3,4 -> id_ex_reg_rd follows 1,2,3,4 one cycle behind, and load_use_stall stays 0 throughout.
